// File: rtl/md_issue_queue.sv
// rtl/md_issue_queue.sv - in-order HI/LO request queue in front of the multiply/divide unit
// Optional MDQ_FLUSH_EN: adds a flush input that drops queued work and suppresses issue.
module md_issue_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        reset,
`ifdef MDQ_FLUSH_EN
    input  logic        flush,
`endif
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_type,
    input  logic        req_write,
    input  logic        req_dst,
    input  logic        req_unsigned,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        hlu_busy,
    output logic [3:0]  hlu_type,
    output logic        hlu_write,
    output logic        hlu_dst,
    output logic        hlu_unsigned,
    output logic [31:0] hlu_a,
    output logic [31:0] hlu_b,
    input  logic        rd_req,
    input  logic        rd_dst,
    output logic        rd_stall
);

    typedef struct packed {
        logic [3:0]  typ;
        logic        write;
        logic        dst;
        logic        uns;
        logic [31:0] a;
        logic [31:0] b;
    } entry_t;

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    entry_t           mem [DEPTH];
    entry_t           head_e;
    entry_t           new_e;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;
    logic             issue_q;
    logic             dst_q;
    logic             flush_now;
    logic             push;
    logic             issue;

`ifdef MDQ_FLUSH_EN
    assign flush_now = flush;
`else
    assign flush_now = 1'b0;
`endif

    assign req_ready = (count != FULL_CNT);
    assign head_e    = mem[head];
    assign new_e     = '{req_type, req_write, req_dst, req_unsigned, req_a, req_b};
    assign push      = req_valid & req_ready & ((req_type != 4'd0) | req_write) & ~flush_now;
    // issue_q covers the one cycle before the unit's busy flag reflects a new mult/div
    assign issue     = (count != '0) & ~hlu_busy & ~issue_q & ~flush_now;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= new_e;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            issue_q      <= 1'b0;
            hlu_type     <= 4'd0;
            hlu_write    <= 1'b0;
            dst_q        <= 1'b0;
            hlu_unsigned <= 1'b0;
            hlu_a        <= 32'd0;
            hlu_b        <= 32'd0;
        end else if (flush_now) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            issue_q   <= 1'b0;
            hlu_type  <= 4'd0;
            hlu_write <= 1'b0;
        end else begin
            if (push) begin
                tail <= tail + PTR_ONE;
            end
            if (issue) begin
                head <= head + PTR_ONE;
            end
            if (push && !issue) begin
                count <= count + CNT_ONE;
            end else if (issue && !push) begin
                count <= count - CNT_ONE;
            end
            issue_q <= issue & (head_e.typ != 4'd0);
            if (issue) begin
                hlu_type     <= head_e.typ;
                hlu_write    <= head_e.write;
                dst_q        <= head_e.dst;
                hlu_unsigned <= head_e.uns;
                hlu_a        <= head_e.a;
                hlu_b        <= head_e.b;
            end else begin
                hlu_type  <= 4'd0;
                hlu_write <= 1'b0;
            end
        end
    end

    assign hlu_dst  = hlu_write ? dst_q : rd_dst;
    assign rd_stall = rd_req & (req_valid | (count != '0) | (hlu_type != 4'd0) |
                                hlu_write | issue_q | hlu_busy);

endmodule

// File: tb/tb_md_issue_queue.sv
// tb/tb_md_issue_queue.sv - directed plus randomized check of md_issue_queue against a queue model
module tb_md_issue_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
`ifdef MDQ_FLUSH_EN
    logic        flush;
`endif
    logic        req_valid, req_ready, req_write, req_dst, req_unsigned;
    logic [3:0]  req_type;
    logic [31:0] req_a, req_b;
    logic        hlu_busy;
    logic [3:0]  hlu_type;
    logic        hlu_write, hlu_dst, hlu_unsigned;
    logic [31:0] hlu_a, hlu_b;
    logic        rd_req, rd_dst, rd_stall;

    always #5 clk = ~clk;

    md_issue_queue #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk(clk), .reset(reset),
`ifdef MDQ_FLUSH_EN
        .flush(flush),
`endif
        .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
        .req_write(req_write), .req_dst(req_dst), .req_unsigned(req_unsigned),
        .req_a(req_a), .req_b(req_b), .hlu_busy(hlu_busy),
        .hlu_type(hlu_type), .hlu_write(hlu_write), .hlu_dst(hlu_dst),
        .hlu_unsigned(hlu_unsigned), .hlu_a(hlu_a), .hlu_b(hlu_b),
        .rd_req(rd_req), .rd_dst(rd_dst), .rd_stall(rd_stall)
    );

    typedef struct {
        logic [3:0]  typ;
        logic        wr;
        logic        dst;
        logic        uns;
        logic [31:0] a;
        logic [31:0] b;
    } ent_t;

    ent_t        q[$];
    logic [3:0]  m_type;
    logic        m_write, m_dst, m_uns, m_issue_q, m_pushed;
    logic [31:0] m_a, m_b;
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          ucnt = 0;
    bit          unit_mode = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_type = 0; m_write = 0; m_dst = 0; m_uns = 0; m_issue_q = 0;
        m_a = 0; m_b = 0; m_pushed = 0;
    endtask

    task automatic model_edge();
        bit   fl, do_issue, do_push;
        ent_t e;
        m_pushed = 0;
        if (!reset) return;
        fl = 0;
`ifdef MDQ_FLUSH_EN
        fl = flush;
`endif
        if (fl) begin
            q.delete();
            m_type = 0; m_write = 0; m_issue_q = 0;
            return;
        end
        do_issue = (q.size() != 0) && !hlu_busy && !m_issue_q;
        do_push  = req_valid && (q.size() < DEPTH) && ((req_type != 0) || req_write);
        if (do_issue) begin
            e = q.pop_front();
            m_type = e.typ; m_write = e.wr; m_dst = e.dst; m_uns = e.uns;
            m_a = e.a; m_b = e.b;
            m_issue_q = (e.typ != 0);
        end else begin
            m_type = 0; m_write = 0; m_issue_q = 0;
        end
        if (do_push) begin
            q.push_back('{req_type, req_write, req_dst, req_unsigned, req_a, req_b});
            m_pushed = 1;
        end
    endtask

    task automatic check_all();
        chk("req_ready", req_ready, q.size() != DEPTH);
        chk("hlu_type", hlu_type, m_type);
        chk("hlu_write", hlu_write, m_write);
        chk("hlu_dst", hlu_dst, m_write ? m_dst : rd_dst);
        chk("hlu_unsigned", hlu_unsigned, m_uns);
        chk("hlu_a", hlu_a, m_a);
        chk("hlu_b", hlu_b, m_b);
        chk("rd_stall", rd_stall, rd_req & (req_valid | (q.size() != 0) | (m_type != 0) |
                                            m_write | m_issue_q | hlu_busy));
    endtask

    // busy rises once a strobe is seen and stays up a few cycles, like the real unit
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        check_all();
        if (unit_mode) begin
            if (hlu_type != 0) ucnt = $urandom_range(2, 4);
            else if (ucnt > 0) ucnt--;
            hlu_busy = (ucnt > 0);
        end
    endtask

    task automatic drive(input logic [3:0] t, input logic w, input logic d, input logic u,
                         input logic [31:0] a, input logic [31:0] b);
        req_valid = 1; req_type = t; req_write = w; req_dst = d; req_unsigned = u;
        req_a = a; req_b = b;
    endtask

    task automatic idle();
        req_valid = 0; req_type = 0; req_write = 0; req_dst = 0; req_unsigned = 0;
        req_a = 0; req_b = 0;
    endtask

    int   got_a[$];
    int   got_c[$];
    bit   busy_seen, write_seen, write_prev;

    initial begin
        reset = 0; hlu_busy = 0; rd_req = 0; rd_dst = 0;
`ifdef MDQ_FLUSH_EN
        flush = 0;
`endif
        idle();
        model_reset();
        @(negedge clk); @(negedge clk);
        reset = 1;
        check_all();

        // reset mid-operation with three entries queued and a strobe live
        hlu_busy = 1;
        for (int i = 0; i < 4; i++) begin
            drive(4'b0001, 0, 0, 0, 32'(10 + i), 32'd7);
            cycle();
        end
        idle(); hlu_busy = 0;
        cycle();
        chk("pre_reset_type", hlu_type, 4'b0001);
        reset = 0; rd_req = 1;
        #1;
        model_reset();
        chk("reset_ready", req_ready, 1);
        chk("reset_type", hlu_type, 0);
        chk("reset_a", hlu_a, 0);
        chk("reset_stall", rd_stall, 0);
        @(negedge clk);
        reset = 1; rd_req = 0;
        cycle();

        // single signed mult
        drive(4'b0001, 0, 0, 0, 32'd3, 32'hFFFFFFFE);
        cycle();
        idle();
        cycle();
        chk("mult_strobe", hlu_type, 4'b0001);
        chk("mult_a", hlu_a, 32'd3);
        chk("mult_b", hlu_b, 32'hFFFFFFFE);
        cycle();
        chk("mult_once", hlu_type, 0);
        cycle();
        chk("mult_empty", hlu_type, 0);

        // fill behind a busy unit, fifth request held off
        hlu_busy = 1;
        for (int i = 0; i < 4; i++) begin
            drive(4'b0010, 0, 0, 1, 32'(i), 32'd9);
            cycle();
        end
        chk("fill_ready", req_ready, 0);
        drive(4'b0010, 0, 0, 1, 32'd4, 32'd9);
        cycle();
        chk("fill_held", req_ready, 0);
        unit_mode = 1; ucnt = 0; hlu_busy = 0;
        got_a.delete(); got_c.delete();
        for (int i = 0; i < 60; i++) begin
            cycle();
            if (m_pushed) idle();
            if (hlu_type != 0) begin
                got_a.push_back(int'(hlu_a));
                got_c.push_back(cyc);
            end
        end
        chk("fill_strobes", got_a.size(), 5);
        for (int k = 0; k < got_a.size(); k++) begin
            chk("fill_order", got_a[k], k);
            if (k > 0) chk("fill_gap", (got_c[k] - got_c[k-1]) >= 2, 1);
        end

        // mult followed by mtlo must wait for the unit
        drive(4'b0001, 0, 0, 1, 32'd5, 32'd6);
        cycle();
        drive(4'b0000, 1, 0, 0, 32'h1234, 32'd0);
        cycle();
        idle();
        busy_seen = 0; write_seen = 0; write_prev = 0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (write_prev) chk("mtlo_one_cycle", hlu_write, 0);
            write_prev = 0;
            if (hlu_busy && !write_seen) busy_seen = 1;
            if (hlu_write) begin
                chk("mtlo_dst", hlu_dst, 0);
                chk("mtlo_a", hlu_a, 32'h1234);
                chk("mtlo_after_busy", busy_seen, 1);
                write_seen = 1; write_prev = 1;
            end
        end
        chk("mtlo_seen", write_seen, 1);

        // read stall
        unit_mode = 0; hlu_busy = 1;
        drive(4'b0001, 0, 0, 0, 32'd1, 32'd2);
        cycle();
        idle(); rd_req = 1;
        #1;
        chk("rd_stall_queued", rd_stall, 1);
        hlu_busy = 0; rd_req = 0;
        for (int i = 0; i < 5; i++) cycle();
        rd_req = 1; rd_dst = 1;
        #1;
        chk("rd_stall_idle", rd_stall, 0);
        chk("rd_dst_follow1", hlu_dst, 1);
        rd_dst = 0;
        #1;
        chk("rd_dst_follow0", hlu_dst, 0);
        rd_req = 0;
        cycle();

`ifdef MDQ_FLUSH_EN
        hlu_busy = 1;
        for (int i = 0; i < 3; i++) begin
            drive(4'b0010, 0, 0, 0, 32'(20 + i), 32'd1);
            cycle();
        end
        idle(); flush = 1;
        cycle();
        flush = 0;
        chk("flush_ready", req_ready, 1);
        hlu_busy = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("flush_no_strobe", hlu_type, 0);
        end
`endif

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            unit_mode = (i < 300);
            if ($urandom_range(0, 1) == 1) begin
                if ($urandom_range(0, 3) == 0)
                    drive(4'b0000, 1, 1'($urandom), 1'($urandom), $urandom, $urandom);
                else
                    drive(4'($urandom_range(0, 2)), 0, 1'($urandom), 1'($urandom), $urandom, $urandom);
            end else begin
                idle();
            end
            rd_req = 1'($urandom); rd_dst = 1'($urandom);
            if (!unit_mode) hlu_busy = ($urandom_range(0, 2) == 0);
`ifdef MDQ_FLUSH_EN
            flush = ($urandom_range(0, 40) == 0);
`endif
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
